// File: rtl/alarm_snooze_ctrl_if.sv
// Signal bundle between the alarm clock / user controls and alarm_snooze_ctrl.
// The master drives the alarm level and buttons; the slave (controller) drives buzzer and status.
interface alarm_snooze_ctrl_if;
  logic       alarm_in;
  logic       snooze_btn;
  logic       stop_btn;
  logic       snooze_enable;
  logic       buzzer;
  logic       stop_alarm;
  logic [1:0] state;
  logic [9:0] snooze_left;
  logic [1:0] snooze_count;
  logic       missed;

  modport master (
    output alarm_in, snooze_btn, stop_btn, snooze_enable,
    input  buzzer, stop_alarm, state, snooze_left, snooze_count, missed
  );

  modport slave (
    input  alarm_in, snooze_btn, stop_btn, snooze_enable,
    output buzzer, stop_alarm, state, snooze_left, snooze_count, missed
  );
endinterface

// File: rtl/alarm_snooze_ctrl.sv
// Ring / snooze / lockout controller clocked by the 1 Hz tick.
// One shared 10-bit timer counts ring time up, snooze and lockout time down.
module alarm_snooze_ctrl #(
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_TIMEOUT = 120,
  parameter int ESCALATE_SEC = 10,
  parameter int LOCKOUT_SEC  = 60,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic               clock_1s,
  input  logic               reset,
  alarm_snooze_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [9:0] SNOOZE_INIT  = 10'(SNOOZE_SEC);
  localparam logic [9:0] LOCKOUT_INIT = 10'(LOCKOUT_SEC);
  localparam logic [9:0] RING_LAST    = 10'(RING_TIMEOUT - 1);
  localparam logic [9:0] ESCALATE_AT  = 10'(ESCALATE_SEC);
  localparam logic [2:0] SNOOZE_LIMIT = 3'(MAX_SNOOZE);

  state_t     state_q;
  logic [9:0] timer_q;
  logic [1:0] snooze_count_q;
  logic       missed_q;
  logic       snooze_ok;

  assign snooze_ok = bus.snooze_btn && bus.snooze_enable &&
                     ({1'b0, snooze_count_q} < SNOOZE_LIMIT);

  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      snooze_count_q <= '0;
      missed_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.alarm_in) begin
            state_q        <= RING;
            timer_q        <= '0;
            missed_q       <= 1'b0;
            snooze_count_q <= '0;
          end
        end
        // Stop outranks snooze, and both outrank the timeout.
        RING: begin
          if (bus.stop_btn) begin
            state_q <= DONE;
            timer_q <= LOCKOUT_INIT;
          end else if (snooze_ok) begin
            state_q        <= SNOOZE;
            timer_q        <= SNOOZE_INIT;
            snooze_count_q <= snooze_count_q + 2'd1;
          end else if (timer_q == RING_LAST) begin
            state_q  <= DONE;
            timer_q  <= LOCKOUT_INIT;
            missed_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 10'd1;
          end
        end
        SNOOZE: begin
          if (bus.stop_btn) begin
            state_q <= DONE;
            timer_q <= LOCKOUT_INIT;
          end else if (timer_q == 10'd1) begin
            state_q <= RING;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - 10'd1;
          end
        end
        // Lockout keeps stop_alarm high long enough for the alarm minute to pass.
        DONE: begin
          if (timer_q == 10'd1) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - 10'd1;
          end
        end
      endcase
    end
  end

  assign bus.buzzer       = (state_q == RING) && ((timer_q >= ESCALATE_AT) || !timer_q[0]);
  assign bus.stop_alarm   = (state_q == SNOOZE) || (state_q == DONE);
  assign bus.state        = state_q;
  assign bus.snooze_left  = (state_q == SNOOZE) ? timer_q : 10'd0;
  assign bus.snooze_count = snooze_count_q;
  assign bus.missed       = missed_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Self-checking bench for alarm_snooze_ctrl: directed scenarios then random buttons,
// compared every tick against an elapsed/remaining-seconds model of the alarm behaviour.
module tb_alarm_snooze_ctrl;

  localparam int SNOOZE_SEC   = 300;
  localparam int RING_TIMEOUT = 120;
  localparam int ESCALATE_SEC = 10;
  localparam int LOCKOUT_SEC  = 60;
  localparam int MAX_SNOOZE   = 3;

  logic clock_1s = 1'b0;
  logic reset;

  alarm_snooze_ctrl_if bus ();

  alarm_snooze_ctrl #(
    .SNOOZE_SEC  (SNOOZE_SEC),
    .RING_TIMEOUT(RING_TIMEOUT),
    .ESCALATE_SEC(ESCALATE_SEC),
    .LOCKOUT_SEC (LOCKOUT_SEC),
    .MAX_SNOOZE  (MAX_SNOOZE)
  ) dut (
    .clock_1s(clock_1s),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 clock_1s = ~clock_1s;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: phase plus seconds rung, seconds of snooze left, seconds of lockout left.
  int m_phase;
  int m_rung;
  int m_snooze_rem;
  int m_lock_rem;
  int m_count;
  int m_missed;

  task automatic modelReset();
    m_phase = 0; m_rung = 0; m_snooze_rem = 0; m_lock_rem = 0;
    m_count = 0; m_missed = 0;
  endtask

  task automatic modelTick(input bit alarm, input bit snooze, input bit stop, input bit enable);
    if (m_phase == 0) begin
      if (alarm) begin
        m_phase = 1; m_rung = 0; m_missed = 0; m_count = 0;
      end
    end else if (m_phase == 1) begin
      if (stop) begin
        m_phase = 3; m_lock_rem = LOCKOUT_SEC;
      end else if (snooze && enable && m_count < MAX_SNOOZE) begin
        m_phase = 2; m_snooze_rem = SNOOZE_SEC; m_count++;
      end else if (m_rung + 1 == RING_TIMEOUT) begin
        m_phase = 3; m_lock_rem = LOCKOUT_SEC; m_missed = 1;
      end else begin
        m_rung++;
      end
    end else if (m_phase == 2) begin
      if (stop) begin
        m_phase = 3; m_lock_rem = LOCKOUT_SEC;
      end else if (m_snooze_rem == 1) begin
        m_phase = 1; m_rung = 0;
      end else begin
        m_snooze_rem--;
      end
    end else begin
      if (m_lock_rem == 1) m_phase = 0;
      else m_lock_rem--;
    end
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    end
  endtask

  task automatic compareModel();
    int exp_buzzer;
    exp_buzzer = (m_phase == 1 && (m_rung >= ESCALATE_SEC || m_rung % 2 == 0)) ? 1 : 0;
    checkOutput("state",        int'(bus.state),        m_phase);
    checkOutput("buzzer",       int'(bus.buzzer),       exp_buzzer);
    checkOutput("stop_alarm",   int'(bus.stop_alarm),   (m_phase == 2 || m_phase == 3) ? 1 : 0);
    checkOutput("snooze_left",  int'(bus.snooze_left),  (m_phase == 2) ? m_snooze_rem : 0);
    checkOutput("snooze_count", int'(bus.snooze_count), m_count);
    checkOutput("missed",       int'(bus.missed),       m_missed);
  endtask

  // Drive one tick's inputs, let the edge happen, then compare just after it.
  task automatic applyStimulus(input bit alarm, input bit snooze, input bit stop, input bit enable);
    bus.alarm_in      = alarm;
    bus.snooze_btn    = snooze;
    bus.stop_btn      = stop;
    bus.snooze_enable = enable;
    @(posedge clock_1s);
    modelTick(alarm, snooze, stop, enable);
    #1;
    compareModel();
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.alarm_in = 1'b0; bus.snooze_btn = 1'b0; bus.stop_btn = 1'b0; bus.snooze_enable = 1'b1;
    modelReset();
    #3;
    compareModel();
    #9 reset = 1'b0;

    // Ring with the 1-on/1-off pattern escalating to continuous, then first snooze.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idleTicks(14);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("first_snooze_left", int'(bus.snooze_left), SNOOZE_SEC);
    idleTicks(SNOOZE_SEC + 12);

    // Use up the remaining snoozes; the fourth request must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleTicks(SNOOZE_SEC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleTicks(SNOOZE_SEC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("fourth_snooze_state", int'(bus.state), 1);
    checkOutput("fourth_snooze_count", int'(bus.snooze_count), 3);

    // Let it time out, then sit out the lockout.
    idleTicks(RING_TIMEOUT);
    checkOutput("timeout_missed", int'(bus.missed), 1);
    idleTicks(LOCKOUT_SEC + 3);

    // Stop and snooze together: stop wins; then stop halfway through a snooze.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idleTicks(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    idleTicks(LOCKOUT_SEC);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleTicks(SNOOZE_SEC - 150);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    idleTicks(LOCKOUT_SEC);

    // Snooze disabled: request ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idleTicks(3);

    // Asynchronous reset in the middle of a snooze, no edge required.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleTicks(20);
    #3 reset = 1'b1;
    #1;
    modelReset();
    compareModel();
    #1 reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    idleTicks(5);

    // Random buttons and alarm levels.
    for (int i = 0; i < 6000; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alarm_snooze_ctrl.md
Name: alarm_snooze_ctrl

Overview:
Downstream stage of the alarm clock. It consumes the clock's Alarm level and runs a ring/snooze/lockout state machine on the 1 Hz tick. It drives a patterned buzzer output and returns stop_alarm to the clock's STOP_alarm input, so the clock's Alarm stays cleared while snoozing and after dismissal.

Parameters:
SNOOZE_SEC, 300, snooze length in seconds; range 2..1023
RING_TIMEOUT, 120, maximum ring time in seconds before auto-dismiss; range 2..1023
ESCALATE_SEC, 10, seconds of 1-on/1-off beeping before the buzzer goes continuous
LOCKOUT_SEC, 60, seconds stop_alarm is held after dismissal; must be >= 60 so the matching alarm minute passes
MAX_SNOOZE, 3, maximum snoozes per alarm event; range 0..3

Ports:
clock_1s  in  1  1 Hz tick; all state updates on rising edge
reset  in  1  asynchronous, active-high
alarm_in  in  1  Alarm output of the alarm clock (level)
snooze_btn  in  1  snooze request; level, sampled on each edge
stop_btn  in  1  dismiss request; level, sampled on each edge
snooze_enable  in  1  1 = snooze permitted
buzzer  out  1  buzzer drive
stop_alarm  out  1  to the clock's STOP_alarm input
state  out  2  0 IDLE, 1 RING, 2 SNOOZE, 3 DONE
snooze_left  out  10  seconds of snooze remaining; 0 outside SNOOZE
snooze_count  out  2  snoozes used in the current event
missed  out  1  sticky: last event auto-dismissed by timeout

Behaviour:
- Reset values, applied immediately on reset and holding while reset=1:
  - state IDLE; timer 0; snooze_count 0; missed 0.
  - Derived outputs therefore: buzzer 0, stop_alarm 0, snooze_left 0.
- A single 10-bit timer is used; its meaning depends on state.
- Output decode from registers only:
  - buzzer = (state==RING) && (timer >= ESCALATE_SEC || timer[0]==0).
  - stop_alarm = (state==SNOOZE || state==DONE).
  - snooze_left = timer when state==SNOOZE, else 0.
- IDLE:
  - alarm_in=1 at an edge -> RING, timer=0, missed=0, snooze_count=0.
  - Latency is one edge: buzzer=1 immediately after that edge.
- RING: checked in priority order at each edge.
  - 1. stop_btn=1 -> DONE, timer=LOCKOUT_SEC.
  - 2. snooze_btn=1 && snooze_enable && snooze_count<MAX_SNOOZE -> SNOOZE, timer=SNOOZE_SEC, snooze_count+1.
  - 3. timer==RING_TIMEOUT-1 -> DONE, timer=LOCKOUT_SEC, missed=1.
  - 4. Otherwise timer+1.
  - Buzzer is active for exactly RING_TIMEOUT cycles if not dismissed.
- RING, corner cases:
  - A snooze request that is not permitted (disabled or limit reached) is ignored; ringing continues.
  - stop_btn and snooze_btn together: stop wins.
  - RING is held by internal state, not by alarm_in; alarm_in is ignored outside IDLE.
- SNOOZE:
  - stop_btn=1 -> DONE, timer=LOCKOUT_SEC.
  - Else timer==1 -> RING, timer=0 (snooze lasts SNOOZE_SEC cycles).
  - Else timer-1.
  - snooze_btn is ignored in SNOOZE.
- DONE:
  - timer==1 -> IDLE, timer=0.
  - Else timer-1.
  - Buttons are ignored.
  - stop_alarm is held for LOCKOUT_SEC cycles, so the clock cannot re-raise Alarm during the matched minute.
- snooze_count persists through DONE; it is cleared only on the IDLE->RING transition or reset.
- missed is set only by timeout; it is cleared on the next IDLE->RING transition or reset.
- No arithmetic wraps: timer is bounded by the parameter ranges.
- snooze_count saturates at MAX_SNOOZE by construction.
- Reset mid-RING or mid-SNOOZE:
  - Everything returns to reset values.
  - stop_alarm drops, so the clock may re-raise Alarm; the block re-rings if alarm_in=1 after reset.

Test Plan:
1. Reset, then alarm_in=1 for one edge -> state=1, buzzer pattern 1,0,1,0... for 10 edges then continuous 1; stop_alarm=0.
2. Ring 5 s, then snooze_btn=1 -> state=2, snooze_left=300, snooze_count=1, stop_alarm=1, buzzer=0. After 300 edges -> state=1, timer restarts, buzzer=1.
3. snooze_enable=1, snooze four times within one event -> fourth request ignored; state stays 1; snooze_count=3.
4. Ring with no buttons -> after 120 edges state=3, missed=1, stop_alarm=1. After 60 more edges -> state=0, stop_alarm=0.
5. stop_btn and snooze_btn both 1 in RING -> state=3, snooze_count unchanged. stop_btn during SNOOZE (snooze_left=150) -> state=3, snooze_left=0.
6. Assert reset asynchronously mid-SNOOZE -> immediately state=0, stop_alarm=0, snooze_count=0, missed=0, with no clock edge needed.
